// File: rtl/add_scheduler.sv
// ============================================================================
// Module   : add_scheduler
// Brief    : Round-robin scheduler sharing one WIDTH-bit carry-select adder
//            between two requesters; wide ops take two chained passes.
//            Define ADD_SCHED_OVF_EN to build the signed-overflow output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module add_scheduler #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [2*WIDTH-1:0] req0_a,
    input  logic [2*WIDTH-1:0] req0_b,
    input  logic               req0_sub,
    input  logic               req0_wide,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [2*WIDTH-1:0] req1_a,
    input  logic [2*WIDTH-1:0] req1_b,
    input  logic               req1_sub,
    input  logic               req1_wide,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_id,
    output logic [2*WIDTH-1:0] res_sum,
    output logic               res_cout,
    output logic               res_ovf
);

    localparam int c_NBLK = WIDTH / 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [2*WIDTH-1:0] r_a;
    logic [2*WIDTH-1:0] r_b;
    logic               r_sub;
    logic               r_wide;
    logic               r_id;
    logic               r_last;
    logic [2*WIDTH-1:0] r_sum;
    logic               r_cout;

    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_accept;

    logic [WIDTH-1:0]   w_pa;
    logic [WIDTH-1:0]   w_pb;
    logic               w_cin;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;

    // ------------------------------------------------------------------
    // FSM and arbitration
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_gnt0   = 1'b0;
        w_gnt1   = 1'b0;
        case (r_state)
            IDLE: begin
                // r_last = 1 means requester 1 was granted last, so 0 wins a tie
                if (!rst) begin
                    if (req0_valid && (!req1_valid || r_last)) begin
                        w_gnt0 = 1'b1;
                    end else if (req1_valid) begin
                        w_gnt1 = 1'b1;
                    end
                end
                if (w_gnt0 || w_gnt1) begin
                    w_next = LO;
                end
            end
            LO:      w_next = r_wide ? HI : DONE;
            HI:      w_next = DONE;
            DONE:    w_next = res_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
        w_accept = w_gnt0 | w_gnt1;
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    // ------------------------------------------------------------------
    // Adder operand selection: HI pass uses upper halves and the LO carry
    // ------------------------------------------------------------------
    always_comb begin
        if (r_state == HI) begin
            w_pa  = r_a[2*WIDTH-1:WIDTH];
            w_pb  = r_sub ? ~r_b[2*WIDTH-1:WIDTH] : r_b[2*WIDTH-1:WIDTH];
            w_cin = r_cout;
        end else begin
            w_pa  = r_a[WIDTH-1:0];
            w_pb  = r_sub ? ~r_b[WIDTH-1:0] : r_b[WIDTH-1:0];
            w_cin = r_sub;
        end
    end

    // ------------------------------------------------------------------
    // Carry-select adder: each nibble precomputes both carry-in cases
    // ------------------------------------------------------------------
    logic [4:0] w_s0 [c_NBLK];
    logic [4:0] w_s1 [c_NBLK];

    for (genvar k = 0; k < c_NBLK; k++) begin : g_blk
        assign w_s0[k] = {1'b0, w_pa[4*k +: 4]} + {1'b0, w_pb[4*k +: 4]};
        assign w_s1[k] = {1'b0, w_pa[4*k +: 4]} + {1'b0, w_pb[4*k +: 4]} + 5'd1;
    end

    always_comb begin : carry_select
        logic w_carry;
        w_carry = w_cin;
        w_sum   = '0;
        for (int k = 0; k < c_NBLK; k++) begin
            w_sum[4*k +: 4] = w_carry ? w_s1[k][3:0] : w_s0[k][3:0];
            w_carry         = w_carry ? w_s1[k][4]   : w_s0[k][4];
        end
        w_cout = w_carry;
    end

    // ------------------------------------------------------------------
    // Operand latch and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_sub  <= 1'b0;
            r_wide <= 1'b0;
            r_id   <= 1'b0;
            r_last <= 1'b1;
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a    <= w_gnt1 ? req1_a    : req0_a;
                r_b    <= w_gnt1 ? req1_b    : req0_b;
                r_sub  <= w_gnt1 ? req1_sub  : req0_sub;
                r_wide <= w_gnt1 ? req1_wide : req0_wide;
                r_id   <= w_gnt1;
                r_last <= w_gnt1;
            end
            if (r_state == LO) begin
                r_sum  <= {{WIDTH{1'b0}}, w_sum};
                r_cout <= w_cout;
            end else if (r_state == HI) begin
                r_sum[2*WIDTH-1:WIDTH] <= w_sum;
                r_cout                 <= w_cout;
            end
        end
    end

`ifdef ADD_SCHED_OVF_EN
    logic r_ovf;
    logic w_ovf;

    assign w_ovf = (w_pa[WIDTH-1] == w_pb[WIDTH-1]) && (w_sum[WIDTH-1] != w_pa[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == LO || r_state == HI) begin
            r_ovf <= w_ovf;
        end
    end

    assign res_ovf = r_ovf;
`else
    assign res_ovf = 1'b0;
`endif

    assign res_valid = (r_state == DONE);
    assign res_id    = r_id;
    assign res_sum   = r_sum;
    assign res_cout  = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_add_scheduler.sv
// ============================================================================
// Module   : tb_add_scheduler
// Brief    : Directed and randomized checks of add_scheduler against an
//            arithmetic reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_add_scheduler;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req0_valid = 1'b0, req1_valid = 1'b0;
    logic           req0_ready, req1_ready;
    logic [2*W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic           req0_sub = 1'b0, req0_wide = 1'b0;
    logic           req1_sub = 1'b0, req1_wide = 1'b0;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic           res_id;
    logic [2*W-1:0] res_sum;
    logic           res_cout;
    logic           res_ovf;

    int n_assert = 0;
    int n_fail   = 0;

    add_scheduler #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sub   (req0_sub),
        .req0_wide  (req0_wide),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sub   (req1_sub),
        .req1_wide  (req1_wide),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_sum    (res_sum),
        .res_cout   (res_cout),
        .res_ovf    (res_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain modular arithmetic on the full operand width.
    function automatic void model(input logic [2*W-1:0] a, input logic [2*W-1:0] b,
                                  input logic sub, input logic wide,
                                  output logic [2*W-1:0] s, output logic c, output logic v);
        logic [2*W:0] t;
        logic sa, sb, sr;
        if (wide) begin
            t  = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
            s  = t[2*W-1:0];
            c  = sub ? ~t[2*W] : t[2*W];
            sa = a[2*W-1];
            sb = b[2*W-1];
            sr = t[2*W-1];
        end else begin
            t  = sub ? ({{(W+1){1'b0}}, a[W-1:0]} - {{(W+1){1'b0}}, b[W-1:0]})
                     : ({{(W+1){1'b0}}, a[W-1:0]} + {{(W+1){1'b0}}, b[W-1:0]});
            s  = {{W{1'b0}}, t[W-1:0]};
            c  = sub ? ~t[W] : t[W];
            sa = a[W-1];
            sb = b[W-1];
            sr = t[W-1];
        end
`ifdef ADD_SCHED_OVF_EN
        v = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
`else
        v = 1'b0 & sa & sb & sr;
`endif
    endfunction

    task automatic drive(input int id, input logic vld, input logic [2*W-1:0] a,
                         input logic [2*W-1:0] b, input logic sub, input logic wide);
        if (id == 0) begin
            req0_valid = vld; req0_a = a; req0_b = b; req0_sub = sub; req0_wide = wide;
        end else begin
            req1_valid = vld; req1_a = a; req1_b = b; req1_sub = sub; req1_wide = wide;
        end
    endtask

    function automatic logic rdy(input int id);
        return (id == 0) ? req0_ready : req1_ready;
    endfunction

    // Called at the negedge of T+1 (valid already dropped); checks latency,
    // result, stability under stall, and the handshake.
    task automatic finish_op(input int id, input logic [2*W-1:0] a, input logic [2*W-1:0] b,
                             input logic sub, input logic wide, input int stall, input string tag);
        logic [2*W-1:0] es;
        logic ec, ev;
        int lat;
        model(a, b, sub, wide, es, ec, ev);
        lat = 1;
        while (!res_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, wide ? 3 : 2);
        check({tag, " sum"}, res_sum, es);
        check({tag, " cout"}, res_cout, ec);
        check({tag, " ovf"}, res_ovf, ev);
        check({tag, " id"}, res_id, id);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, " stall valid"}, res_valid, 1'b1);
            check({tag, " stall sum"}, res_sum, es);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, " valid drop"}, res_valid, 1'b0);
    endtask

    task automatic run_op(input int id, input logic [2*W-1:0] a, input logic [2*W-1:0] b,
                          input logic sub, input logic wide, input int stall, input string tag);
        int k;
        drive(id, 1'b1, a, b, sub, wide);
        #1;
        k = 0;
        while (!rdy(id) && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        check({tag, " accept"}, rdy(id), 1'b1);
        @(negedge clk);
        drive(id, 1'b0, a, b, sub, wide);
        finish_op(id, a, b, sub, wide, stall, tag);
    endtask

    initial begin
        int g[$];
        int gc[$];
        int ids[$];

        // Reset with both requesters asserting: nothing accepted
        drive(0, 1'b1, 64'd1, 64'd2, 1'b0, 1'b0);
        drive(1, 1'b1, 64'd3, 64'd4, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst ready0", req0_ready, 1'b0);
        check("rst ready1", req1_ready, 1'b0);
        check("rst valid", res_valid, 1'b0);
        check("rst sum", res_sum, '0);
        check("rst id", res_id, 1'b0);
        check("rst cout", res_cout, 1'b0);
        check("rst ovf", res_ovf, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        run_op(0, 64'h5, 64'h3, 1'b0, 1'b0, 0, "add");
        run_op(1, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b1, 0, "wide");
        run_op(0, 64'h8000_0000, 64'h1, 1'b1, 1'b0, 0, "subovf");
        run_op(1, 64'h0, 64'h1, 1'b1, 1'b1, 1, "wsub");

        // Round-robin with both requesters continuously valid
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        drive(0, 1'b1, 64'h10, 64'h20, 1'b0, 1'b0);
        drive(1, 1'b1, 64'h30, 64'h40, 1'b0, 1'b0);
        res_ready = 1'b1;
        rst = 1'b0;
        for (int c = 0; c < 40 && ids.size() < 4; c++) begin
            #1;
            check("rr exclusive", req0_ready & req1_ready, 1'b0);
            if (req0_ready) begin g.push_back(0); gc.push_back(c); end
            else if (req1_ready) begin g.push_back(1); gc.push_back(c); end
            if (res_valid) ids.push_back(int'(res_id));
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready  = 1'b0;
        check("rr results", ids.size(), 4);
        for (int i = 0; i < 4 && i < ids.size() && i < g.size(); i++) begin
            check("rr grant", g[i], i % 2);
            check("rr id", ids[i], g[i]);
            if (i > 0) check("rr interval", gc[i] - gc[i-1], 3);
        end

        // Backpressure with a request pending on requester 1
        @(negedge clk);
        drive(0, 1'b1, 64'h1234, 64'h1111, 1'b0, 1'b0);
        #1;
        check("bp accept0", req0_ready, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, 64'h1234, 64'h1111, 1'b0, 1'b0);
        drive(1, 1'b1, 64'h7, 64'h9, 1'b0, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("bp valid", res_valid, 1'b1);
            check("bp sum", res_sum, 64'h2345);
            check("bp id", res_id, 1'b0);
            check("bp ready0", req0_ready, 1'b0);
            check("bp ready1", req1_ready, 1'b0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        #1;
        res_ready = 1'b0;
        check("bp valid drop", res_valid, 1'b0);
        check("bp pending accept", req1_ready, 1'b1);
        @(negedge clk);
        drive(1, 1'b0, 64'h7, 64'h9, 1'b0, 1'b1);
        finish_op(1, 64'h7, 64'h9, 1'b0, 1'b1, 0, "bp op1");

        // Reset during HI of a wide operation
        drive(1, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b1);
        #1;
        check("mid accept", req1_ready, 1'b1);
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("mid valid", res_valid, 1'b0);
        check("mid sum", res_sum, '0);
        check("mid cout", res_cout, 1'b0);
        check("mid ovf", res_ovf, 1'b0);
        check("mid id", res_id, 1'b0);
        drive(0, 1'b1, 64'h40, 64'h2, 1'b1, 1'b0);
        drive(1, 1'b1, 64'h50, 64'h3, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check("mid grant0", req0_ready, 1'b1);
        check("mid grant1", req1_ready, 1'b0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        finish_op(0, 64'h40, 64'h2, 1'b1, 1'b0, 0, "mid op0");

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            logic [2*W-1:0] ra, rb;
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) rb = ra;
            run_op(int'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/add_scheduler.md
# add_scheduler

Shared-adder scheduler for the CPU datapath. It arbitrates between two requesters, such as the ALU issue port and the address-generation port, for a single `WIDTH`-bit carry-select adder instance. It sequences single-width operations in one adder pass and double-width operations in two passes, chaining the carry between them. Results are returned on a registered valid/ready output port tagged with the requester ID.

## Interface
Parameters:
- `WIDTH`, default 32: width of the shared adder. It must be a multiple of 4 and at least 8.

Ports (`reqN` applies to N = 0 and 1):
- `clk` in 1: the single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `reqN_valid` in 1: requester N presents an operation.
- `reqN_ready` out 1: requester N's operation is accepted this cycle.
- `reqN_a` in 2*WIDTH: operand A. Single-width operations use only `[WIDTH-1:0]`.
- `reqN_b` in 2*WIDTH: operand B. Single-width operations use only `[WIDTH-1:0]`.
- `reqN_sub` in 1: 1 selects A − B; 0 selects A + B.
- `reqN_wide` in 1: 1 selects a 2*WIDTH operation; 0 selects a WIDTH operation.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `res_id` out 1: index of the requester that owns the result.
- `res_sum` out 2*WIDTH: result. The upper half is 0 for single-width operations.
- `res_cout` out 1: carry-out of the final adder pass.
- `res_ovf` out 1: signed overflow of the final pass (see Configuration).

## Operation
- FSM states: IDLE, LO, HI, DONE. Reset state is IDLE.
- **IDLE**
  - `reqN_ready` is combinational: it is 1 only for the arbitration winner, and only while that requester's `reqN_valid` = 1.
  - Only one requester wins per cycle.
  - On acceptance, the block latches A, B, sub, wide and the requester ID, then moves to LO.
- **Arbitration**
  - If exactly one requester is valid, it wins.
  - If both are valid, the requester not granted most recently wins (round-robin).
  - The last-grant pointer resets to 1, so requester 0 wins the first tie.
- **Operand conditioning**
  - When sub = 1, the adder B input is ~B.
  - Carry-in for the first pass equals sub.
- **LO**
  - The adder computes A[WIDTH-1:0] + B'[WIDTH-1:0] + cin.
  - The block registers the low sum, carry-out and overflow.
  - If wide = 0, the next state is DONE. Otherwise it is HI.
- **HI**
  - The adder computes A[2W-1:W] + B'[2W-1:W] + the registered LO carry.
  - The block registers the high sum and overwrites the carry and overflow with this pass's values.
  - The next state is DONE.
- **DONE**
  - `res_valid` = 1 and all `res_*` outputs are held stable.
  - When `res_valid` && `res_ready`, the next state is IDLE. Otherwise the block stays in DONE indefinitely.
- Both `reqN_ready` outputs are 0 in LO, HI and DONE.
- Arithmetic is modulo 2^(WIDTH) per pass and 2^(2*WIDTH) overall.
- For subtraction, `res_cout` = 1 means no borrow.

## Timing
- Reset values: `res_valid`, `res_id`, `res_sum`, `res_cout` and `res_ovf` are all 0. Both `reqN_ready` outputs are 0 while `rst` = 1.
- Acceptance happens in cycle T.
  - Single-width: `res_valid` rises in T+2.
  - Double-width: `res_valid` rises in T+3.
- After the `res_valid` && `res_ready` handshake in cycle D, the block can accept a new request in D+1. Minimum initiation interval is 3 cycles for single-width and 4 for double-width.
- Requests arriving while busy wait; `reqN_valid` must be held until `reqN_ready`.
- The ID output is stable from `res_valid` rising until the handshake completes.
- Reset asserted mid-operation: the block returns to IDLE on the next edge, discards the in-flight operation, clears `res_valid`, and resets the round-robin pointer. No partial result is emitted.
- If both requesters assert simultaneously with reset, neither is accepted.

## Configuration
- `ADD_SCHED_OVF_EN` defined:
  - `res_ovf` = signed overflow of the final pass, computed as (sign of A' == sign of B') && (sign of sum != sign of A').
  - Sign bits are WIDTH-1 for single-width and 2*WIDTH-1 for double-width.
  - For subtraction, the sign of B' is the sign of ~B.
- Not defined: `res_ovf` is tied to 0 and no overflow register is built.

## Test plan
- **Single-width add:** req0 with a=0x0000_0005, b=0x0000_0003, sub=0, wide=0 → `res_valid` in T+2; `res_sum`=0x...0008, `res_cout`=0, `res_id`=0.
- **Double-width carry chain:** req1 with a=0x0000_0000_FFFF_FFFF, b=1, wide=1 → `res_valid` in T+3; `res_sum`=0x0000_0001_0000_0000, `res_cout`=0, `res_id`=1.
- **Subtraction and overflow:** sub=1, a=0x8000_0000, b=1, narrow → `res_sum`=0x7FFF_FFFF, `res_cout`=1, `res_ovf`=1 when the macro is defined and 0 when it is not.
- **Round-robin fairness:** both requesters valid continuously after reset, `res_ready`=1 → grant order 0,1,0,1, with each `res_id` matching the grant.
- **Backpressure:** hold `res_ready`=0 for 5 cycles after `res_valid` → outputs are stable and both `reqN_ready` stay 0. Raise `res_ready` → `res_valid` drops the next cycle and the pending requester is accepted in that cycle.
- **Reset mid-operation:** assert `rst` in HI of a wide operation → next cycle all outputs are 0 and the state is IDLE. Deassert with both requesters valid → req0 is granted.
